// File: rtl/tree_noc_pkg.sv
// Shared definitions for the N-ary fat-tree router: port indexing,
// the per-flit routing decision and the grant-index width.
package tree_noc_pkg;

  typedef struct packed {
    logic       drop;
    logic [7:0] out_idx;
  } route_t;

  // Children occupy ports 0..radix-1, the parent is always the last port.
  function automatic int parent_port(input int radix);
    return radix;
  endfunction

  function automatic int grant_w(input int radix);
    return $clog2(radix + 1);
  endfunction

  // dest is zero-extended, so everything above the child field is the prefix.
  function automatic route_t route(input logic [31:0] dest, input int shift,
                                   input logic [31:0] node_id, input logic is_root,
                                   input int src, input int radix);
    route_t     r;
    logic [7:0] child;
    logic       match;
    int         lr;
    lr        = $clog2(radix);
    child     = 8'((dest >> shift) & ((32'd1 << lr) - 32'd1));
    match     = is_root || ((dest >> (shift + lr)) == node_id);
    r.drop    = (src == parent_port(radix)) && !match;
    r.out_idx = match ? child : 8'(parent_port(radix));
    return r;
  endfunction

endpackage

// File: rtl/tree_router_nary_if.sv
// Bundle of all child/parent flit channels plus status outputs of one router node.
interface tree_router_nary_if
  import tree_noc_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int RADIX = 2,
  parameter int GW    = grant_w(RADIX)
);
  logic [RADIX-1:0][WIDTH-1:0] ch_in_data;
  logic [RADIX-1:0]            ch_in_valid;
  logic [RADIX-1:0]            ch_in_ready;
  logic [RADIX-1:0][WIDTH-1:0] ch_out_data;
  logic [RADIX-1:0]            ch_out_valid;
  logic [RADIX-1:0]            ch_out_ready;
  logic [WIDTH-1:0]            p_in_data;
  logic                        p_in_valid;
  logic                        p_in_ready;
  logic [WIDTH-1:0]            p_out_data;
  logic                        p_out_valid;
  logic                        p_out_ready;
  logic [RADIX:0][GW-1:0]      out_grant_src;
  logic [7:0]                  err_drop;

  modport slave (
    input  ch_in_data, ch_in_valid, ch_out_ready, p_in_data, p_in_valid, p_out_ready,
    output ch_in_ready, ch_out_data, ch_out_valid, p_in_ready, p_out_data, p_out_valid,
    output out_grant_src, err_drop
  );

  modport master (
    output ch_in_data, ch_in_valid, ch_out_ready, p_in_data, p_in_valid, p_out_ready,
    input  ch_in_ready, ch_out_data, ch_out_valid, p_in_ready, p_out_data, p_out_valid,
    input  out_grant_src, err_drop
  );
endinterface

// File: rtl/flit_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; the head is
// readable combinationally so the router can route it in the same cycle.
module flit_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready is held low while reset is applied, so nothing is accepted then.
  assign in_ready  = (count_q != CW'(DEPTH)) && !srst;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = bump(wr_ptr_q);
    if (pop)  rd_ptr_d = bump(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: rtl/tree_router_nary.sv
// One node of an N-ary fat-tree: per-input FIFO + destination decode,
// per-output registered round-robin merge, and a saturating drop counter.
module tree_router_nary
  import tree_noc_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int ADDR_W  = 4,
  parameter int RADIX   = 2,
  parameter int SHIFT   = 1,
  parameter int NODE_ID = 0,
  parameter int IS_ROOT = 0,
  parameter int DEPTH   = 2
) (
  input logic               CLK,
  input logic               RESET,
  tree_router_nary_if.slave bus
);
  localparam int NP     = RADIX + 1;
  localparam int PARENT = parent_port(RADIX);
  localparam int GW     = grant_w(RADIX);

  logic [WIDTH-1:0] in_data   [NP];
  logic [NP-1:0]    in_valid, in_ready;
  logic [WIDTH-1:0] head_data [NP];
  logic [NP-1:0]    head_valid, head_pop, drop_v;
  route_t           rt        [NP];
  logic [NP-1:0]    gnt       [NP];
  logic [WIDTH-1:0] out_data  [NP];
  logic [NP-1:0]    out_valid, out_ready;
  logic [7:0]       err_drop_q, err_drop_d;

  for (genvar gi = 0; gi < NP; gi++) begin : g_in
    if (gi < RADIX) begin : g_child
      assign in_data[gi]         = bus.ch_in_data[gi];
      assign in_valid[gi]        = bus.ch_in_valid[gi];
      assign bus.ch_in_ready[gi] = in_ready[gi];
    end else begin : g_parent
      assign in_data[gi]    = bus.p_in_data;
      assign in_valid[gi]   = bus.p_in_valid && (IS_ROOT == 0);
      assign bus.p_in_ready = (IS_ROOT != 0) ? 1'b1 : in_ready[gi];
    end

    flit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk      (CLK),
      .srst     (RESET),
      .in_data  (in_data[gi]),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .out_data (head_data[gi]),
      .out_valid(head_valid[gi]),
      .out_ready(head_pop[gi])
    );

    assign rt[gi] = route(32'(head_data[gi][WIDTH-1 -: ADDR_W]), SHIFT, 32'(NODE_ID),
                          IS_ROOT != 0, gi, RADIX);
    assign drop_v[gi] = head_valid[gi] && rt[gi].drop;
  end

  // A head leaves its FIFO either by being dropped or by winning its output.
  always_comb begin
    head_pop = drop_v;
    for (int o = 0; o < NP; o++) head_pop = head_pop | gnt[o];
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_out
    logic [NP-1:0]    req, win;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d, src_q, src_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    int               idx;

    always_comb begin
      req      = '0;
      win      = '0;
      idx      = 0;
      rr_ptr_d = rr_ptr_q;
      src_d    = src_q;
      data_d   = data_q;
      valid_d  = valid_q && !out_ready[gi];
      for (int k = 0; k < NP; k++)
        req[k] = head_valid[k] && !rt[k].drop && (rt[k].out_idx == 8'(gi));
      // Grant only when the register is free or drains this cycle.
      if (!valid_q || out_ready[gi]) begin
        for (int k = 0; k < NP; k++) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= NP) idx = idx - NP;
          if (win == '0 && req[idx]) win[idx] = 1'b1;
        end
        for (int k = 0; k < NP; k++) begin
          if (win[k]) begin
            data_d   = head_data[k];
            src_d    = GW'(k);
            valid_d  = 1'b1;
            rr_ptr_d = (k == NP - 1) ? '0 : GW'(k + 1);
          end
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        rr_ptr_q <= '0;
        src_q    <= '0;
        data_q   <= '0;
        valid_q  <= 1'b0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
        src_q    <= src_d;
        data_q   <= data_d;
        valid_q  <= valid_d;
      end
    end

    assign gnt[gi]               = win;
    assign out_data[gi]          = data_q;
    assign out_valid[gi]         = valid_q;
    assign bus.out_grant_src[gi] = src_q;
  end

  for (genvar gi = 0; gi < RADIX; gi++) begin : g_ch_out
    assign bus.ch_out_data[gi]  = out_data[gi];
    assign bus.ch_out_valid[gi] = out_valid[gi];
    assign out_ready[gi]        = bus.ch_out_ready[gi];
  end
  assign bus.p_out_data    = out_data[PARENT];
  assign bus.p_out_valid   = out_valid[PARENT] && (IS_ROOT == 0);
  assign out_ready[PARENT] = bus.p_out_ready;

  // Only the parent input can drop, so at most one increment per cycle.
  always_comb begin
    err_drop_d = err_drop_q;
    if ((|drop_v) && err_drop_q != 8'hFF) err_drop_d = err_drop_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) err_drop_q <= '0;
    else       err_drop_q <= err_drop_d;
  end

  assign bus.err_drop = err_drop_q;
endmodule
